// File: rtl/pixel_packer.sv
// pixel_packer: packs 24-bit RGB pixels into 32-bit AXI4-Stream words
// (four pixels -> three words). Carries SOF as TUSER and EOL as TLAST.
// Partial groups at end of line are flushed as PAD_BYTE-padded words.
// Optional statistics counters: define PIXEL_PACKER_STATS_EN.
module pixel_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [7:0]  in_r,
  input  logic [7:0]  in_g,
  input  logic [7:0]  in_b,
  input  logic        in_valid,
  input  logic        in_sof,
  input  logic        in_eol,
  output logic        in_ready,
  output logic [31:0] out_tdata,
  output logic        out_tvalid,
  input  logic        out_tready,
  output logic        out_tuser,
  output logic        out_tlast,
  output logic        sof_misalign
`ifdef PIXEL_PACKER_STATS_EN
  ,
  output logic [15:0] frame_count,
  output logic [31:0] word_count
`endif
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t      state;
  logic [1:0]  phase;
  logic [23:0] residue;
  logic [31:0] flush_word;
  logic        sof_pending;

  logic        out_free;
  logic        accept;
  logic [1:0]  eff_phase;
  logic        load_word;
  logic [31:0] load_data;
  logic        load_last;
  logic        go_flush;
  logic [31:0] next_flush_word;
  logic [23:0] next_residue;
  logic [1:0]  next_phase;

  assign out_free  = !out_tvalid || out_tready;
  assign in_ready  = (state == RUN) && out_free;
  assign accept    = in_valid && in_ready;
  // An SOF pixel always starts a fresh group, whatever was pending.
  assign eff_phase = in_sof ? 2'd0 : phase;

  // Word assembly and residue update for the pixel being accepted.
  always_comb begin
    load_word       = 1'b0;
    load_data       = '0;
    load_last       = 1'b0;
    go_flush        = 1'b0;
    next_flush_word = flush_word;
    next_residue    = residue;
    next_phase      = phase;
    case (eff_phase)
      2'd0: begin
        load_word    = in_eol;
        load_data    = {PAD_BYTE, in_b, in_g, in_r};
        load_last    = 1'b1;
        next_residue = {in_b, in_g, in_r};
        next_phase   = 2'd1;
      end
      2'd1: begin
        load_word       = 1'b1;
        load_data       = {in_r, residue[23:0]};
        load_last       = 1'b0;
        next_residue    = {8'h00, in_b, in_g};
        next_phase      = 2'd2;
        go_flush        = in_eol;
        next_flush_word = {PAD_BYTE, PAD_BYTE, in_b, in_g};
      end
      2'd2: begin
        load_word       = 1'b1;
        load_data       = {in_g, in_r, residue[15:0]};
        load_last       = 1'b0;
        next_residue    = {16'h0000, in_b};
        next_phase      = 2'd3;
        go_flush        = in_eol;
        next_flush_word = {PAD_BYTE, PAD_BYTE, PAD_BYTE, in_b};
      end
      default: begin
        load_word    = 1'b1;
        load_data    = {in_b, in_g, in_r, residue[7:0]};
        load_last    = in_eol;
        next_residue = '0;
        next_phase   = 2'd0;
      end
    endcase
    if (in_eol) begin
      next_phase   = 2'd0;
      next_residue = '0;
    end
  end

  // RUN/FLUSH control with the single-entry registered output stage.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= RUN;
      phase        <= 2'd0;
      residue      <= '0;
      flush_word   <= '0;
      sof_pending  <= 1'b0;
      sof_misalign <= 1'b0;
      out_tdata    <= '0;
      out_tvalid   <= 1'b0;
      out_tuser    <= 1'b0;
      out_tlast    <= 1'b0;
    end else begin
      if (out_tvalid && out_tready) begin
        out_tvalid <= 1'b0;
      end
      case (state)
        RUN: begin
          if (accept) begin
            phase   <= next_phase;
            residue <= next_residue;
            if (in_sof && (phase != 2'd0)) begin
              sof_misalign <= 1'b1;
            end
            if (load_word) begin
              out_tdata   <= load_data;
              out_tvalid  <= 1'b1;
              out_tuser   <= sof_pending || in_sof;
              out_tlast   <= load_last;
              sof_pending <= 1'b0;
            end else if (in_sof) begin
              sof_pending <= 1'b1;
            end
            if (go_flush) begin
              flush_word <= next_flush_word;
              state      <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (out_free) begin
            out_tdata   <= flush_word;
            out_tvalid  <= 1'b1;
            out_tuser   <= sof_pending;
            out_tlast   <= 1'b1;
            sof_pending <= 1'b0;
            state       <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef PIXEL_PACKER_STATS_EN
  // Handshake counters: all words, and words that start a frame.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      word_count  <= '0;
      frame_count <= '0;
    end else if (out_tvalid && out_tready) begin
      word_count <= word_count + 32'd1;
      if (out_tuser) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end
`endif

endmodule
